// File: rtl/bcd_pkg.sv
// bcd_pkg: shared states, digit constants and validity check for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
    localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
    localparam logic [3:0] BCD_CORR_SUB    = 4'd3;

    // Checks the low n digits (n <= 16) of a zero-extended packed-BCD word.
    function automatic logic digits_valid(input logic [63:0] bcd, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (i < n && bcd[4*i +: 4] > BCD_DIGIT_MAX) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// bcd_digit_corr: reverse double-dabble digit correction, subtract 3 from digits >= 8.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_CORR_THRESH) ? d - BCD_CORR_SUB : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter (reverse double-dabble, start/done).
// Optional signed result with sign_in when BCD2BIN_SIGN_EN is defined.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
`ifdef BCD2BIN_SIGN_EN
    input  logic                  sign_in,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W:0]        bin_out
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    if ((2 ** BIN_W) <= (10 ** DIGITS - 1)) begin : g_width_check
        $error("BIN_W too small to hold 10^DIGITS-1");
    end

    state_t                state;
    logic [4*DIGITS-1:0]   bcd_reg, bcd_sh, bcd_corr;
    logic [BIN_W-1:0]      bin_reg, bin_sh;
    logic [CW-1:0]         cnt;
    logic [BIN_W:0]        result;

    assign bcd_sh = bcd_reg >> 1;
    assign bin_sh = {bcd_reg[0], bin_reg[BIN_W-1:1]};
    assign busy   = (state != IDLE);

    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        bcd_digit_corr u_corr (.d(bcd_sh[4*i +: 4]), .q(bcd_corr[4*i +: 4]));
    end

`ifdef BCD2BIN_SIGN_EN
    logic sign_reg;
    assign result = sign_reg ? -{1'b0, bin_sh} : {1'b0, bin_sh};
`else
    assign result = {1'b0, bin_sh};
`endif

    // Result is loaded on the final shift so done/bin_out are registered in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
`ifdef BCD2BIN_SIGN_EN
            sign_reg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    bcd_reg <= bcd_in;
                    bin_reg <= '0;
                    cnt     <= '0;
`ifdef BCD2BIN_SIGN_EN
                    sign_reg <= sign_in;
`endif
                    if (!digits_valid(64'(bcd_in), DIGITS)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        bin_out <= '0;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_corr;
                    bin_reg <= bin_sh;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        bin_out <= result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq at default parameters.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        sign_in = 1'b0;
    logic        busy, done, err;
    logic [14:0] bin_out;

    int errors = 0;
    int checks = 0;
    logic [14:0] prev_bin = '0;
    logic        prev_err = 1'b0;

    bcd_to_bin_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bcd_in(bcd_in),
`ifdef BCD2BIN_SIGN_EN
        .sign_in(sign_in),
`endif
        .busy(busy),
        .done(done),
        .err(err),
        .bin_out(bin_out)
    );

    always #5 clk = ~clk;

    // Called just after a rising edge; that cycle is cycle 0 of the conversion.
    task automatic convert(input logic [15:0] b, input logic s, input logic [14:0] eb,
                           input logic ee, input int lat, input string nm);
        int dc = -1;
        int bad_busy = 0;
        int bad_hold = 0;
        logic [14:0] gb = 'x;
        logic ge = 1'bx;
        start = 1'b1; bcd_in = b; sign_in = s;
        @(posedge clk); #1;
        start = 1'b0; bcd_in = 16'hFFFF; sign_in = ~s;
        for (int c = 1; c <= 20 && dc < 0; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (done === 1'b1) begin
                dc = c; gb = bin_out; ge = err;
            end else if (bin_out !== prev_bin || err !== prev_err) bad_hold++;
            @(posedge clk); #1;
        end
        checks++;
        if (dc !== lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, dc, lat); end
        checks++;
        if (gb !== eb) begin errors++; $display("FAIL %s bin_out: got %h want %h", nm, gb, eb); end
        checks++;
        if (ge !== ee) begin errors++; $display("FAIL %s err: got %b want %b", nm, ge, ee); end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL %s busy: low in %0d cycles want 0", nm, bad_busy); end
        checks++;
        if (bad_hold != 0) begin errors++; $display("FAIL %s hold: outputs moved in %0d cycles want 0", nm, bad_hold); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL %s idle_after: busy=%b done=%b want 0 0", nm, busy, done);
        end
        prev_bin = eb; prev_err = ee;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, bin_out} !== 18'd0) begin
            errors++; $display("FAIL reset_hold: got %b%b%b %h want all 0", busy, done, err, bin_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err, bin_out} !== 18'd0) begin
            errors++; $display("FAIL reset_idle: got %b%b%b %h want all 0", busy, done, err, bin_out);
        end
    endtask

    task automatic test_convert();
        convert(16'h0000, 1'b0, 15'h0000, 1'b0, 15, "zero");
        convert(16'h9999, 1'b0, 15'h270F, 1'b0, 15, "max");
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        int c1 = -1, c2 = -1;
        logic [14:0] b1 = 'x, b2 = 'x;
        start = 1'b1; bcd_in = 16'h1234;
        @(posedge clk); #1;
        bcd_in = 16'h0567;
        for (int c = 1; c <= 31; c++) begin
            start = (c <= 20);
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) begin c1 = c; b1 = bin_out; end
                if (nd == 2) begin c2 = c; b2 = bin_out; end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (nd != 2) begin errors++; $display("FAIL b2b done_count: got %0d want 2", nd); end
        checks++;
        if (c1 != 15 || b1 !== 15'h04D2) begin
            errors++; $display("FAIL b2b first: cycle %0d bin %h want 15 04d2", c1, b1);
        end
        checks++;
        if (c2 != 31 || b2 !== 15'h0237) begin
            errors++; $display("FAIL b2b second: cycle %0d bin %h want 31 0237", c2, b2);
        end
        prev_bin = 15'h0237; prev_err = 1'b0;
    endtask

    task automatic test_invalid();
        convert(16'h12A4, 1'b0, 15'h0000, 1'b1, 1, "bad_digit");
        convert(16'h0042, 1'b0, 15'h002A, 1'b0, 15, "after_bad");
    endtask

    task automatic test_mid_reset();
        int nd = 0;
        start = 1'b1; bcd_in = 16'h0500;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, err, bin_out} !== 18'd0) begin
            errors++; $display("FAIL mid_reset: got %b%b%b %h want all 0", busy, done, err, bin_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL mid_reset no_done: got %0d dones want 0", nd); end
        @(posedge clk); #1;
        prev_bin = '0; prev_err = 1'b0;
        convert(16'h0500, 1'b0, 15'h01F4, 1'b0, 15, "after_reset");
    endtask

`ifdef BCD2BIN_SIGN_EN
    task automatic test_sign();
        convert(16'h0042, 1'b1, 15'h7FD6, 1'b0, 15, "neg42");
        convert(16'h0000, 1'b1, 15'h0000, 1'b0, 15, "neg_zero");
    endtask
`endif

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_invalid();
        test_mid_reset();
`ifdef BCD2BIN_SIGN_EN
        test_sign();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential multi-digit packed-BCD to unsigned binary converter for the calculator datapath.
- Converts keypad/display-side BCD operands into binary for the ALU. It is the inverse of the binary-to-BCD conversion stage.
- Uses reverse double-dabble: one right-shift plus per-digit correction each cycle, under a start/done handshake.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in.
- BIN_W, 14, binary result width. Requirement: 2^BIN_W > 10^DIGITS - 1; an elaboration-time assertion enforces this.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]; captured in the cycle start is accepted.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- err  output  1  valid with done; some digit was >9.
- bin_out  output  BIN_W+1  result; held stable until the next done.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - state=IDLE; busy=0, done=0, err=0, bin_out=0.
  - Shift register and counter cleared.
  - Reset mid-conversion aborts immediately; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures bcd_in into the BCD shift register, clears the binary register and counter, and checks digits.
  - Any digit >9: go to DONE with err_next=1.
  - Otherwise: go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one iteration per cycle:
  - Shift {bcd_reg, bin_reg} right by 1; the BCD LSB enters the bin MSB.
  - Then every 4-bit digit >=8 has 3 subtracted (mod 16).
  - Counter increments. After BIN_W iterations, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - bin_out is loaded with bin_reg (zero-extended to BIN_W+1), or 0 when err.
  - err is registered with done and held until the next done.
  - Next state is IDLE.
- Latency, with start accepted in cycle 0:
  - Valid input: done in cycle BIN_W+1 (15 at defaults).
  - Invalid input: done in cycle 1.
  - Back-to-back throughput is one conversion per BIN_W+2 cycles.
- start while busy (SHIFT or DONE) is ignored; no queuing.
- bcd_in changes after acceptance have no effect.
- No internal overflow is possible given the BIN_W constraint; all arithmetic is unsigned.

Optional Feature:
- Macro BCD2BIN_SIGN_EN.
- Defined:
  - Adds input sign_in (1 bit), captured with bcd_in.
  - In DONE with sign_in=1 and err=0, bin_out = two's complement negation of the BIN_W+1-bit magnitude.
  - Negative zero yields 0.
- Undefined:
  - sign_in port absent.
  - bin_out MSB is always 0.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Constants BCD_DIGIT_MAX=4'd9, BCD_CORR_THRESH=4'd8, BCD_CORR_SUB=4'd3.
  - Function digits_valid().
- Sub-module bcd_digit_corr: 4-bit in/out; out = in>=8 ? in-3 : in. Instantiated DIGITS times via generate.

Test Plan:
- bcd_in=16'h0000, start pulse -> done in cycle 15, bin_out=0, err=0, busy high cycles 1-15.
- bcd_in=16'h9999 -> done cycle 15, bin_out=15'd9999 (0x270F), err=0.
- bcd_in=16'h1234; start held high in cycles 1-20 -> single done at cycle 15, bin_out=0x04D2. Next conversion accepted only in cycle 16, with its done at cycle 31.
- bcd_in=16'h12A4 -> done at cycle 1, err=1, bin_out=0. Following 16'h0042 -> err=0, bin_out=42.
- rst_n low at cycle 7 of a 16'h0500 conversion -> outputs 0 and IDLE immediately, no done. A new start after release converts correctly.
- BCD2BIN_SIGN_EN defined: bcd_in=16'h0042, sign_in=1 -> bin_out=15'h7FD6. bcd_in=0, sign_in=1 -> bin_out=0.
